// File: rtl/memory_access.sv
// Y86-64 memory stage: M pipeline register, 8-byte little-endian data memory, address fault check.
// Optional build macro MEM_ALIGN_CHECK_EN: when defined, a misaligned access is also an address fault.
module memory_access #(
   parameter int DMEM_BYTES = 1024
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        memory_stall_i,
   input  logic        memory_bubble_i,
   input  logic [3:0]  e_icode_i,
   input  logic [2:0]  e_stat_i,
   input  logic [63:0] e_valE_i,
   input  logic [63:0] e_valA_i,
   input  logic [3:0]  e_dstE_i,
   input  logic [3:0]  e_dstM_i,
   input  logic        e_cnd_i,
   input  logic [2:0]  W_stat_i,
   output logic [3:0]  icode_o,
   output logic [63:0] valE_o,
   output logic [63:0] valA_o,
   output logic [63:0] valM_o,
   output logic [3:0]  dstE_o,
   output logic [3:0]  dstM_o,
   output logic        cnd_o,
   output logic [2:0]  m_stat_o
);
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;
   localparam logic [3:0] RNONE   = 4'hF;
   localparam logic [2:0] SAOK    = 3'd1;
   localparam logic [2:0] SADR    = 3'd2;
   localparam int         AW      = (DMEM_BYTES > 1) ? $clog2(DMEM_BYTES) : 1;

   logic [3:0]  r_icode;
   logic [2:0]  r_stat;
   logic [63:0] r_valE;
   logic [63:0] r_valA;
   logic [3:0]  r_dstE;
   logic [3:0]  r_dstM;
   logic        r_cnd;
   logic [7:0]  r_mem [0:DMEM_BYTES-1];

   logic          w_rd;
   logic          w_wr;
   logic [63:0]   w_addr;
   logic          w_valid;
   logic [2:0]    w_mstat;
   logic          w_we;
   logic [AW-1:0] w_idx;
   logic [63:0]   w_valM;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_icode <= INOP;
         r_stat  <= SAOK;
         r_valE  <= '0;
         r_valA  <= '0;
         r_dstE  <= RNONE;
         r_dstM  <= RNONE;
         r_cnd   <= 1'b0;
      end else if (!memory_stall_i) begin
         if (memory_bubble_i) begin
            r_icode <= INOP;
            r_stat  <= SAOK;
            r_valE  <= '0;
            r_valA  <= '0;
            r_dstE  <= RNONE;
            r_dstM  <= RNONE;
            r_cnd   <= 1'b0;
         end else begin
            r_icode <= e_icode_i;
            r_stat  <= e_stat_i;
            r_valE  <= e_valE_i;
            r_valA  <= e_valA_i;
            r_dstE  <= e_dstE_i;
            r_dstM  <= e_dstM_i;
            r_cnd   <= e_cnd_i;
         end
      end
   end

   always_comb begin
      w_rd    = (r_icode == IMRMOVQ) || (r_icode == IPOPQ) || (r_icode == IRET);
      w_wr    = (r_icode == IRMMOVQ) || (r_icode == IPUSHQ) || (r_icode == ICALL);
      w_addr  = ((r_icode == IPOPQ) || (r_icode == IRET)) ? r_valA : r_valE;
      // Compare the full 64-bit address so nothing near 2^64 can wrap into range.
      w_valid = (w_addr <= 64'(DMEM_BYTES - 8));
`ifdef MEM_ALIGN_CHECK_EN
      w_valid = w_valid && (w_addr[2:0] == 3'b000);
`endif
      w_mstat = ((w_rd || w_wr) && !w_valid && (r_stat == SAOK)) ? SADR : r_stat;
      w_we    = w_wr && (w_mstat == SAOK) && (W_stat_i == SAOK) && !memory_stall_i;
      w_idx   = w_addr[AW-1:0];
   end

   always_comb begin
      w_valM = '0;
      if (w_rd && w_valid) begin
         for (int i = 0; i < 8; i++) w_valM[8*i +: 8] = r_mem[w_idx + AW'(i)];
      end
   end

   // Reset forces M to a bubble asynchronously, so w_we is already low at any edge seen in reset.
   always_ff @(posedge clk_i) begin
      if (w_we) begin
         for (int i = 0; i < 8; i++) r_mem[w_idx + AW'(i)] <= r_valA[8*i +: 8];
      end
   end

   assign icode_o  = r_icode;
   assign valE_o   = r_valE;
   assign valA_o   = r_valA;
   assign valM_o   = w_valM;
   assign dstE_o   = r_dstE;
   assign dstM_o   = r_dstM;
   assign cnd_o    = r_cnd;
   assign m_stat_o = w_mstat;
endmodule
